// File: rtl/ram_arbiter_j68.sv
// ram_arbiter_j68: shares one single-port 16-bit byte-enabled RAM between the
// cpu_j68 bus (master 0) and a second bus master (master 1). Each access is
// sequenced IDLE -> WRITE -> IDLE or IDLE -> READ -> RACK -> IDLE. Ties are
// broken round-robin, or always in favour of master 0 when FIXED_PRIO is set.
module ram_arbiter_j68 #(
    parameter int ADDR_WIDTH = 14,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_ena,
    input  logic                  m0_rd_ena,
    input  logic                  m0_wr_ena,
    input  logic [1:0]            m0_byte_ena,
    input  logic [ADDR_WIDTH-2:0] m0_address,
    input  logic [15:0]           m0_wr_data,
    output logic                  m0_data_ack,
    output logic [15:0]           m0_rd_data,
    input  logic                  m1_rd_ena,
    input  logic                  m1_wr_ena,
    input  logic [1:0]            m1_byte_ena,
    input  logic [ADDR_WIDTH-2:0] m1_address,
    input  logic [15:0]           m1_wr_data,
    output logic                  m1_data_ack,
    output logic [15:0]           m1_rd_data,
    output logic                  ram_wren,
    output logic [1:0]            ram_byteena,
    output logic [ADDR_WIDTH-2:0] ram_address,
    output logic [15:0]           ram_data,
    input  logic [15:0]           ram_q,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RACK} state_t;

    state_t                state;
    logic                  owner;
    logic                  last_grant;
    logic                  m0_req;
    logic                  m1_req;
    logic                  winner;
    logic                  win_wr;
    logic [ADDR_WIDTH-2:0] own_addr;
    logic [1:0]            own_be;
    logic [15:0]           own_data;
    logic                  ack;

    assign m0_req = m0_rd_ena | m0_wr_ena;
    assign m1_req = m1_rd_ena | m1_wr_ena;

    // Choose which requesting master takes the RAM next; a write wins over a read
    // when a master raises both enables.
    always_comb begin
        winner = 1'b0;
        if (m0_req && m1_req) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else if (m1_req) begin
            winner = 1'b1;
        end
        win_wr = winner ? m1_wr_ena : m0_wr_ena;
    end

    // Access sequencer; everything holds while clk_ena is low, reset overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (clk_ena) begin
            case (state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        owner      <= winner;
                        last_grant <= winner;
                        state      <= win_wr ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: state <= S_IDLE;
                S_READ:  state <= S_RACK;
                S_RACK:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Route the owner's bus onto the RAM port and return ack/data to the owner only;
    // the owner's inputs are held stable by the bus protocol until ack.
    always_comb begin
        own_addr    = owner ? m1_address  : m0_address;
        own_be      = owner ? m1_byte_ena : m0_byte_ena;
        own_data    = owner ? m1_wr_data  : m0_wr_data;
        ack         = (state == S_WRITE) || (state == S_RACK);
        ram_wren    = (state == S_WRITE);
        ram_address = (state != S_IDLE) ? own_addr : '0;
        ram_byteena = (state != S_IDLE) ? own_be   : 2'b00;
        ram_data    = (state == S_WRITE) ? own_data : 16'h0000;
        m0_data_ack = ack && !owner;
        m1_data_ack = ack && owner;
        m0_rd_data  = (state == S_RACK && !owner) ? ram_q : 16'h0000;
        m1_rd_data  = (state == S_RACK && owner)  ? ram_q : 16'h0000;
        grant       = (state == S_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    end

endmodule

// File: tb/tb_ram_arbiter_j68.sv
// Bench for ram_arbiter_j68: directed protocol cases plus randomized two-master
// traffic against a transaction-level model, on a round-robin and a
// fixed-priority instance, each with its own behavioural RAM.
module tb_ram_arbiter_j68;

    localparam int AW = 13;

    logic clk = 1'b0;
    logic rst;
    logic clk_ena;

    logic          rd_ena [2][2];
    logic          wr_ena [2][2];
    logic [1:0]    be     [2][2];
    logic [AW-1:0] addr   [2][2];
    logic [15:0]   wdat   [2][2];
    logic          ack    [2][2];
    logic [15:0]   rdd    [2][2];
    logic          ram_wren [2];
    logic [1:0]    ram_be   [2];
    logic [AW-1:0] ram_addr [2];
    logic [15:0]   ram_dout [2];
    logic [15:0]   ram_q    [2];
    logic [1:0]    grant    [2];

    logic [15:0] mem    [2][8192];
    logic [15:0] shadow [2][8192];
    int          model_last [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter_j68 #(.ADDR_WIDTH(14), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst), .clk_ena(clk_ena),
        .m0_rd_ena(rd_ena[0][0]), .m0_wr_ena(wr_ena[0][0]), .m0_byte_ena(be[0][0]),
        .m0_address(addr[0][0]), .m0_wr_data(wdat[0][0]),
        .m0_data_ack(ack[0][0]), .m0_rd_data(rdd[0][0]),
        .m1_rd_ena(rd_ena[0][1]), .m1_wr_ena(wr_ena[0][1]), .m1_byte_ena(be[0][1]),
        .m1_address(addr[0][1]), .m1_wr_data(wdat[0][1]),
        .m1_data_ack(ack[0][1]), .m1_rd_data(rdd[0][1]),
        .ram_wren(ram_wren[0]), .ram_byteena(ram_be[0]), .ram_address(ram_addr[0]),
        .ram_data(ram_dout[0]), .ram_q(ram_q[0]), .grant(grant[0])
    );

    ram_arbiter_j68 #(.ADDR_WIDTH(14), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst), .clk_ena(clk_ena),
        .m0_rd_ena(rd_ena[1][0]), .m0_wr_ena(wr_ena[1][0]), .m0_byte_ena(be[1][0]),
        .m0_address(addr[1][0]), .m0_wr_data(wdat[1][0]),
        .m0_data_ack(ack[1][0]), .m0_rd_data(rdd[1][0]),
        .m1_rd_ena(rd_ena[1][1]), .m1_wr_ena(wr_ena[1][1]), .m1_byte_ena(be[1][1]),
        .m1_address(addr[1][1]), .m1_wr_data(wdat[1][1]),
        .m1_data_ack(ack[1][1]), .m1_rd_data(rdd[1][1]),
        .ram_wren(ram_wren[1]), .ram_byteena(ram_be[1]), .ram_address(ram_addr[1]),
        .ram_data(ram_dout[1]), .ram_q(ram_q[1]), .grant(grant[1])
    );

    // Behavioural RAMs: byte-enabled write, one-cycle registered read, cleared on reset.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 8192; i++) mem[d][i] <= 16'h0000;
            end else if (ram_wren[d]) begin
                if (ram_be[d][1]) mem[d][ram_addr[d]][15:8] <= ram_dout[d][15:8];
                if (ram_be[d][0]) mem[d][ram_addr[d]][7:0]  <= ram_dout[d][7:0];
            end
            ram_q[d] <= mem[d][ram_addr[d]];
        end
    end

    task automatic drive(input int d, input int m, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [1:0] b, input logic [15:0] v);
        rd_ena[d][m] = rd;
        wr_ena[d][m] = wr;
        addr[d][m]   = a;
        be[d][m]     = b;
        wdat[d][m]   = v;
    endtask

    task automatic clear_all();
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) drive(d, m, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        model_last[0] = 1;
        model_last[1] = 1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8192; i++) shadow[d][i] = 16'h0000;
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        clear_model();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 1'b1, 1'b0, 13'h0555, 2'b11, 16'hFFFF);
        drive(0, 1, 1'b0, 1'b1, 13'h0AAA, 2'b11, 16'hFFFF);
        clear_model();
        step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++; if (grant[d] !== 2'b00) begin n_fail++; $display("FAIL reset_grant dut%0d got=%b exp=00", d, grant[d]); end
            n_chk++; if (ram_wren[d] !== 1'b0) begin n_fail++; $display("FAIL reset_wren dut%0d got=%b exp=0", d, ram_wren[d]); end
        end
        n_chk++; if (ack[0][0] !== 1'b0 || ack[0][1] !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b%b exp=00", ack[0][1], ack[0][0]); end
        n_chk++; if (ram_addr[0] !== '0 || ram_be[0] !== 2'b00 || ram_dout[0] !== 16'h0) begin n_fail++; $display("FAIL reset_ram got addr=%h be=%b data=%h exp=0", ram_addr[0], ram_be[0], ram_dout[0]); end
        n_chk++; if (rdd[0][0] !== 16'h0 || rdd[0][1] !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got=%h/%h exp=0", rdd[0][0], rdd[0][1]); end
        clear_all();
        step();
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (grant[0] !== 2'b00) begin n_fail++; $display("FAIL reset_idle_grant got=%b exp=00", grant[0]); end
    endtask

    task automatic test_single_write();
        step();
        drive(0, 0, 1'b0, 1'b1, 13'h0123, 2'b11, 16'hA55A);
        @(negedge clk);
        n_chk++; if (grant[0] !== 2'b00 || ack[0][0] !== 1'b0) begin n_fail++; $display("FAIL wr_cycleN got grant=%b ack=%b exp 00/0", grant[0], ack[0][0]); end
        step();
        @(negedge clk);
        n_chk++; if (ram_wren[0] !== 1'b1) begin n_fail++; $display("FAIL wr_wren got=%b exp=1", ram_wren[0]); end
        n_chk++; if (ram_addr[0] !== 13'h0123) begin n_fail++; $display("FAIL wr_addr got=%h exp=0123", ram_addr[0]); end
        n_chk++; if (ram_dout[0] !== 16'hA55A) begin n_fail++; $display("FAIL wr_data got=%h exp=a55a", ram_dout[0]); end
        n_chk++; if (ram_be[0] !== 2'b11) begin n_fail++; $display("FAIL wr_be got=%b exp=11", ram_be[0]); end
        n_chk++; if (ack[0][0] !== 1'b1) begin n_fail++; $display("FAIL wr_m0_ack got=%b exp=1", ack[0][0]); end
        n_chk++; if (ack[0][1] !== 1'b0) begin n_fail++; $display("FAIL wr_m1_ack got=%b exp=0", ack[0][1]); end
        n_chk++; if (grant[0] !== 2'b01) begin n_fail++; $display("FAIL wr_grant got=%b exp=01", grant[0]); end
        step();
        clear_all();
        @(negedge clk);
        n_chk++; if (grant[0] !== 2'b00 || ack[0][0] !== 1'b0 || ram_wren[0] !== 1'b0) begin n_fail++; $display("FAIL wr_back_idle got grant=%b ack=%b wren=%b exp 00/0/0", grant[0], ack[0][0], ram_wren[0]); end
    endtask

    task automatic test_single_read();
        step();
        drive(0, 1, 1'b1, 1'b0, 13'h0123, 2'b11, 16'h0000);
        @(negedge clk);
        n_chk++; if (rdd[0][1] !== 16'h0) begin n_fail++; $display("FAIL rd_data_N got=%h exp=0", rdd[0][1]); end
        step();
        @(negedge clk);
        n_chk++; if (ram_addr[0] !== 13'h0123 || ram_wren[0] !== 1'b0) begin n_fail++; $display("FAIL rd_addr got addr=%h wren=%b exp 0123/0", ram_addr[0], ram_wren[0]); end
        n_chk++; if (grant[0] !== 2'b10) begin n_fail++; $display("FAIL rd_grant got=%b exp=10", grant[0]); end
        n_chk++; if (ack[0][1] !== 1'b0 || rdd[0][1] !== 16'h0) begin n_fail++; $display("FAIL rd_early got ack=%b data=%h exp 0/0", ack[0][1], rdd[0][1]); end
        step();
        @(negedge clk);
        n_chk++; if (ack[0][1] !== 1'b1) begin n_fail++; $display("FAIL rd_ack got=%b exp=1", ack[0][1]); end
        n_chk++; if (rdd[0][1] !== 16'hA55A) begin n_fail++; $display("FAIL rd_data got=%h exp=a55a", rdd[0][1]); end
        n_chk++; if (ack[0][0] !== 1'b0 || rdd[0][0] !== 16'h0) begin n_fail++; $display("FAIL rd_nonowner got ack=%b data=%h exp 0/0", ack[0][0], rdd[0][0]); end
        step();
        clear_all();
        @(negedge clk);
        n_chk++; if (ack[0][1] !== 1'b0 || rdd[0][1] !== 16'h0 || grant[0] !== 2'b00) begin n_fail++; $display("FAIL rd_after got ack=%b data=%h grant=%b exp 0/0/00", ack[0][1], rdd[0][1], grant[0]); end
    endtask

    task automatic test_withdraw();
        step();
        drive(0, 0, 1'b1, 1'b0, 13'h0123, 2'b11, 16'h0000);
        step();
        rd_ena[0][0] = 1'b0;
        step();
        @(negedge clk);
        n_chk++; if (ack[0][0] !== 1'b1 || rdd[0][0] !== 16'hA55A) begin n_fail++; $display("FAIL withdraw got ack=%b data=%h exp 1/a55a", ack[0][0], rdd[0][0]); end
        step();
        clear_all();
    endtask

    task automatic test_reset_in_read();
        step();
        drive(0, 0, 1'b1, 1'b0, 13'h0010, 2'b11, 16'h0000);
        step();
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (grant[0] !== 2'b01 || ram_wren[0] !== 1'b0) begin n_fail++; $display("FAIL rstrd_in_read got grant=%b wren=%b exp 01/0", grant[0], ram_wren[0]); end
        step();
        rst = 1'b0;
        clear_model();
        drive(0, 1, 1'b1, 1'b0, 13'h0011, 2'b11, 16'h0000);
        @(negedge clk);
        n_chk++; if (ack[0][0] !== 1'b0 || ack[0][1] !== 1'b0) begin n_fail++; $display("FAIL rstrd_no_ack got=%b%b exp=00", ack[0][1], ack[0][0]); end
        n_chk++; if (grant[0] !== 2'b00) begin n_fail++; $display("FAIL rstrd_grant got=%b exp=00", grant[0]); end
        step();
        clear_all();
        @(negedge clk);
        n_chk++; if (grant[0] !== 2'b01) begin n_fail++; $display("FAIL rstrd_tie got=%b exp=01", grant[0]); end
        step();
        step();
    endtask

    task automatic test_clk_ena();
        int k;
        for (k = 0; k < 2; k++) begin
            step();
            if (k == 0) drive(0, 0, 1'b0, 1'b1, 13'h0042, 2'b11, 16'h1234);
            else        drive(0, 1, 1'b0, 1'b1, 13'h0042, 2'b01, 16'hABCD);
            step();
            @(negedge clk);
            n_chk++; if (ack[0][k] !== 1'b1) begin n_fail++; $display("FAIL ena_prewrite m%0d ack got=%b exp=1", k, ack[0][k]); end
            step();
            clear_all();
        end
        step();
        drive(0, 0, 1'b1, 1'b0, 13'h0042, 2'b11, 16'h0000);
        step();
        clk_ena = 1'b0;
        @(negedge clk);
        n_chk++; if (grant[0] !== 2'b01 || ram_addr[0] !== 13'h0042) begin n_fail++; $display("FAIL ena_read got grant=%b addr=%h exp 01/0042", grant[0], ram_addr[0]); end
        for (k = 0; k < 2; k++) begin
            step();
            if (k == 1) clk_ena = 1'b1;
            @(negedge clk);
            n_chk++; if (ack[0][0] !== 1'b0 || grant[0] !== 2'b01) begin n_fail++; $display("FAIL ena_hold%0d got ack=%b grant=%b exp 0/01", k, ack[0][0], grant[0]); end
        end
        step();
        @(negedge clk);
        n_chk++; if (ack[0][0] !== 1'b1 || rdd[0][0] !== 16'h12CD) begin n_fail++; $display("FAIL ena_resume got ack=%b data=%h exp 1/12cd", ack[0][0], rdd[0][0]); end
        step();
        clear_all();
        @(negedge clk);
        n_chk++; if (ack[0][0] !== 1'b0) begin n_fail++; $display("FAIL ena_done got ack=%b exp=0", ack[0][0]); end
    endtask

    // Randomized traffic on instance d. Masters re-request after a random gap of up
    // to gapN cycles (0 = immediately in the cycle after ack). The model tracks the
    // remaining cycles of the current ownership: 1 for a write, 2 for a read, with
    // the ack on the last of them and a free IDLE cycle afterwards.
    task automatic traffic(input int d, input int ncyc, input int gap0, input int gap1, input bit chk_wait);
        int            cnt, own, w, c, k;
        bit            twr, r0, r1, exp_ack;
        logic [AW-1:0] taddr;
        logic [1:0]    tbe;
        logic [15:0]   tdat, exp_rd;
        logic [1:0]    exp_grant;
        bit            act [2];
        bit            seen [2];
        int            gapc [2];
        int            age [2];
        cnt = 0; own = 0; twr = 1'b0; taddr = '0; tbe = 2'b00; tdat = 16'h0;
        for (int m = 0; m < 2; m++) begin act[m] = 1'b0; seen[m] = 1'b0; gapc[m] = 0; age[m] = 0; end
        for (c = 0; ; c++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                if (seen[m]) begin
                    drive(d, m, 1'b0, 1'b0, '0, 2'b00, 16'h0);
                    act[m]  = 1'b0;
                    seen[m] = 1'b0;
                    gapc[m] = $urandom_range((m == 0) ? gap0 : gap1, 0);
                end
                if (!act[m] && c < ncyc) begin
                    if (gapc[m] > 0) gapc[m]--;
                    else begin
                        k = $urandom_range(3, 0);
                        drive(d, m, (k != 2), (k >= 2), AW'($urandom_range(15, 0)),
                              2'($urandom_range(3, 1)), 16'($urandom));
                        act[m] = 1'b1;
                        age[m] = 0;
                    end
                end
            end
            if (c >= ncyc && !act[0] && !act[1] && cnt == 0) break;
            if (c >= ncyc + 50) begin
                n_chk++; n_fail++;
                $display("FAIL traffic_timeout dut%0d got pending=%0d%0d exp=00", d, act[1], act[0]);
                break;
            end
            @(negedge clk);
            exp_grant = (cnt > 0) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
            n_chk++; if (grant[d] !== exp_grant) begin n_fail++; $display("FAIL tr_grant dut%0d cyc%0d got=%b exp=%b", d, c, grant[d], exp_grant); end
            for (int m = 0; m < 2; m++) begin
                exp_ack = (cnt == 1) && (own == m);
                exp_rd  = (exp_ack && !twr) ? shadow[d][taddr] : 16'h0000;
                n_chk++; if (ack[d][m] !== exp_ack) begin n_fail++; $display("FAIL tr_ack dut%0d m%0d cyc%0d got=%b exp=%b", d, m, c, ack[d][m], exp_ack); end
                n_chk++; if (rdd[d][m] !== exp_rd) begin n_fail++; $display("FAIL tr_rdata dut%0d m%0d cyc%0d got=%h exp=%h", d, m, c, rdd[d][m], exp_rd); end
                if (exp_ack) seen[m] = 1'b1;
            end
            n_chk++; if (ram_wren[d] !== (cnt == 1 && twr)) begin n_fail++; $display("FAIL tr_wren dut%0d cyc%0d got=%b exp=%b", d, c, ram_wren[d], (cnt == 1 && twr)); end
            n_chk++; if (ram_addr[d] !== ((cnt > 0) ? taddr : '0)) begin n_fail++; $display("FAIL tr_addr dut%0d cyc%0d got=%h exp=%h", d, c, ram_addr[d], (cnt > 0) ? taddr : '0); end
            if (cnt == 1 && twr) begin
                n_chk++; if (ram_dout[d] !== tdat || ram_be[d] !== tbe) begin n_fail++; $display("FAIL tr_wdata dut%0d cyc%0d got=%h/%b exp=%h/%b", d, c, ram_dout[d], ram_be[d], tdat, tbe); end
                if (tbe[1]) shadow[d][taddr][15:8] = tdat[15:8];
                if (tbe[0]) shadow[d][taddr][7:0]  = tdat[7:0];
            end
            for (int m = 0; m < 2; m++) if (act[m]) age[m]++;
            r0 = rd_ena[d][0] || wr_ena[d][0];
            r1 = rd_ena[d][1] || wr_ena[d][1];
            if (cnt > 0) cnt--;
            else if (r0 || r1) begin
                if (r0 && r1) w = (d == 1) ? 0 : ((model_last[d] == 0) ? 1 : 0);
                else          w = r1 ? 1 : 0;
                own   = w;
                twr   = wr_ena[d][w];
                taddr = addr[d][w];
                tbe   = be[d][w];
                tdat  = wdat[d][w];
                cnt   = twr ? 1 : 2;
                model_last[d] = w;
                if (chk_wait) begin
                    n_chk++; if (age[w] > 4) begin n_fail++; $display("FAIL tr_wait dut%0d m%0d got=%0d cycles exp<=4", d, w, age[w]); end
                end
            end
        end
        clear_all();
    endtask

    initial begin
        clk_ena = 1'b1;
        rst     = 1'b1;
        clear_all();
        test_reset();
        test_single_write();
        test_single_read();
        test_withdraw();
        test_reset_in_read();
        test_clk_ena();
        do_reset();
        traffic(0, 60, 0, 0, 1'b1);
        traffic(0, 200, 3, 3, 1'b1);
        traffic(1, 40, 0, 0, 1'b0);
        traffic(1, 200, 3, 1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
